move_entry: RTL and testbench



---
 rtl/move_entry_if.sv | 21 ++
 rtl/move_entry.sv | 199 +++++++++++++++++++
 tb/tb_move_entry.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_entry_if.sv
// Handshake between the player-side move entry front end and the corral game core.
interface move_entry_if;
  logic       ready;
  logic       gameover;
  logic       enter;
  logic [2:0] move;

  modport master (
    input  ready,
    input  gameover,
    output enter,
    output move
  );

  modport slave (
    output ready,
    output gameover,
    input  enter,
    input  move
  );
endinterface

// File: rtl/move_entry.sv
// Player move entry: button/switch sync and debounce, range check, enter/ready handshake.
// Optional AUTOREPEAT_EN macro: a long hold in RELEASE re-issues the current move.
//
//  state      | meaning
//  -----------+--------------------------------------------------------------
//  WAIT_READY | core not waiting for a move; enter low
//  ARMED      | core waiting; a debounced press launches a move
//  ASSERT     | enter high for ENTER_HOLD_CYCLES; watch for ready to drop
//  RELEASE    | enter low; wait for the button to be released
module move_entry #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int ENTER_HOLD_CYCLES = 4,
  parameter int CNT_W             = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             btn_raw,
  input  logic [2:0]       sw_move_raw,
  move_entry_if.master     core,
  output logic             busy,
  output logic             reject,
  output logic [CNT_W-1:0] moves_made
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(ENTER_HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ENTER_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT_READY = 2'd0,
    S_ARMED      = 2'd1,
    S_ASSERT     = 2'd2,
    S_RELEASE    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_btn_s1, r_btn_s2;
  logic [2:0]        r_sw_s1, r_sw_s2;
  logic              r_btn_db, r_btn_db_d;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_go_d;
  logic              r_enter;
  logic [2:0]        r_move;
  logic              r_busy;
  logic              r_reject;
  logic [CNT_W-1:0]  r_moves_made;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_taken;

  logic w_press;
  logic w_go;
  logic w_go_rise;
  logic w_move_ok;
  logic w_taken_now;

`ifdef AUTOREPEAT_EN
  localparam int REPEAT_CYCLES = 1024;
  localparam logic [9:0] REP_LAST = 10'(REPEAT_CYCLES - 1);
  logic [9:0] r_rep_cnt;
  logic       r_rep_pend;
  assign w_go = w_press | r_rep_pend;
`else
  assign w_go = w_press;
`endif

  assign w_press     = r_btn_db & ~r_btn_db_d;
  assign w_go_rise   = core.gameover & ~r_go_d;
  assign w_move_ok   = (r_sw_s2 >= 3'd1) && (r_sw_s2 <= 3'd5);
  assign w_taken_now = r_taken | ~core.ready;

  assign core.enter  = r_enter;
  assign core.move   = r_move;
  assign busy        = r_busy;
  assign reject      = r_reject;
  assign moves_made  = r_moves_made;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_sw_s1  <= 3'd0;
      r_sw_s2  <= 3'd0;
      r_go_d   <= 1'b0;
    end else begin
      r_btn_s1 <= btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw_move_raw;
      r_sw_s2  <= r_sw_s1;
      r_go_d   <= core.gameover;
    end
  end

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_btn_db_d <= r_btn_db;
      if (r_btn_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_db <= ~r_btn_db;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_WAIT_READY;
      r_enter      <= 1'b0;
      r_move       <= 3'd0;
      r_busy       <= 1'b1;
      r_reject     <= 1'b0;
      r_moves_made <= '0;
      r_hold_cnt   <= '0;
      r_taken      <= 1'b0;
`ifdef AUTOREPEAT_EN
      r_rep_cnt    <= '0;
      r_rep_pend   <= 1'b0;
`endif
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        S_WAIT_READY: begin
          r_enter <= 1'b0;
          if (core.ready) begin
            r_state <= S_ARMED;
            r_busy  <= 1'b0;
          end
        end
        S_ARMED: begin
          if (!core.ready) begin
            r_state <= S_WAIT_READY;
            r_busy  <= 1'b1;
          end else if (w_go) begin
            r_busy <= 1'b1;
`ifdef AUTOREPEAT_EN
            r_rep_pend <= 1'b0;
`endif
            if (w_move_ok) begin
              r_state    <= S_ASSERT;
              r_enter    <= 1'b1;
              r_move     <= r_sw_s2;
              r_hold_cnt <= '0;
              r_taken    <= 1'b0;
            end else begin
              r_reject <= 1'b1;
              r_state  <= S_RELEASE;
            end
          end
        end
        S_ASSERT: begin
          if (!core.ready) r_taken <= 1'b1;
          if (r_hold_cnt != '1) r_hold_cnt <= r_hold_cnt + 1'b1;
          // ready sampled in the final cycle still counts as acceptance
          if (r_hold_cnt == HOLD_LAST) begin
            r_enter <= 1'b0;
            r_state <= S_RELEASE;
            if (w_taken_now) begin
              if (r_moves_made != '1) r_moves_made <= r_moves_made + 1'b1;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
`ifdef AUTOREPEAT_EN
          if (!r_btn_db) begin
            r_rep_cnt <= '0;
            r_state   <= S_WAIT_READY;
          end else if (r_rep_cnt == REP_LAST) begin
            r_rep_cnt  <= '0;
            r_rep_pend <= 1'b1;
            r_state    <= S_WAIT_READY;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
`else
          if (!r_btn_db) r_state <= S_WAIT_READY;
`endif
        end
        default: begin
          r_state <= S_WAIT_READY;
          r_enter <= 1'b0;
          r_busy  <= 1'b1;
        end
      endcase
      // A new game clears the count even if a move is accepted in the same cycle.
      if (w_go_rise) r_moves_made <= '0;
    end
  end

endmodule

// File: tb/tb_move_entry.sv
// Self-checking bench for move_entry: directed scenarios plus randomized presses against a cycle model.
`timescale 1ns/1ps
module tb_move_entry;
  localparam int DEB  = 16;
  localparam int HOLD = 4;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;

  logic          clock       = 1'b0;
  logic          reset_n     = 1'b0;
  logic          btn_raw     = 1'b0;
  logic [2:0]    sw_move_raw = 3'd0;
  logic          busy, reject;
  logic [CW-1:0] moves_made;

  move_entry_if bus();

  move_entry #(.DEBOUNCE_CYCLES(DEB), .ENTER_HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .btn_raw(btn_raw), .sw_move_raw(sw_move_raw),
    .core(bus), .busy(busy), .reject(reject), .moves_made(moves_made)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // core behaviour controls
  int core_mode   = 0;   // 0: ready forced, 1: automatic core
  bit force_ready = 1'b0;
  int acc_max     = 2;
  bit glitch_en   = 1'b0;

  // observation counters
  int enter_rises = 0;
  int rej_seen    = 0;
  bit enter_prev  = 1'b0;

  // reference model: modes 0 idle-core, 1 waiting-for-press, 2 strobing, 3 waiting-for-release
  int m_mode, m_left, m_run, m_moves, m_move, m_sw1, m_sw2;
  bit m_s1, m_s2, m_db, m_db_prev, m_taken, m_reject, m_go_prev;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_run = 0; m_moves = 0; m_move = 0;
    m_sw1 = 0; m_sw2 = 0; m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0;
    m_taken = 0; m_reject = 0; m_go_prev = 0;
    enter_prev = 0;
  endtask

  task automatic model_step();
    bit press, go_rise;
    press   = m_db && !m_db_prev;
    go_rise = bus.gameover && !m_go_prev;
    m_reject = 0;
    case (m_mode)
      0: if (bus.ready) m_mode = 1;
      1: begin
        if (!bus.ready) m_mode = 0;
        else if (press) begin
          if (m_sw2 >= 1 && m_sw2 <= 5) begin
            m_mode = 2; m_move = m_sw2; m_left = HOLD; m_taken = 0;
          end else begin
            m_reject = 1; m_mode = 3;
          end
        end
      end
      2: begin
        if (!bus.ready) m_taken = 1;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = 3;
          if (m_taken) begin
            if (m_moves < SAT) m_moves = m_moves + 1;
          end else m_reject = 1;
        end
      end
      default: if (!m_db) m_mode = 0;
    endcase
    if (go_rise) m_moves = 0;
    m_go_prev = bus.gameover;
    m_db_prev = m_db;
    if (m_s2 != m_db) begin
      m_run = m_run + 1;
      if (m_run == DEB) begin m_db = !m_db; m_run = 0; end
    end else m_run = 0;
    m_s2  = m_s1;  m_s1  = btn_raw;
    m_sw2 = m_sw1; m_sw1 = int'(sw_move_raw);
  endtask

  task automatic check_loop();
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) model_reset();
      else begin
        model_step();
        chk("enter", int'(bus.enter), int'(m_mode == 2));
        chk("busy", int'(busy), int'(m_mode != 1));
        chk("reject", int'(reject), int'(m_reject));
        chk("moves_made", int'(moves_made), m_moves);
        if (m_mode == 2) chk("move", int'(bus.move), m_move);
        if (bus.enter && !enter_prev) enter_rises++;
        if (reject) rej_seen++;
        enter_prev = bus.enter;
      end
    end
  endtask

  task automatic core_loop();
    int acc_dly = 0;
    int rdy_dly = 0;
    bus.ready = 1'b0;
    forever begin
      @(negedge clock);
      if (core_mode == 0) bus.ready = force_ready;
      else if (bus.enter) begin
        if (bus.ready) begin
          if (acc_dly <= 0) bus.ready = 1'b0;
          else acc_dly--;
        end
      end else if (!bus.ready) begin
        if (rdy_dly <= 0) begin
          bus.ready = 1'b1;
          rdy_dly = int'($urandom_range(0, 20));
        end else rdy_dly--;
      end else begin
        acc_dly = int'($urandom_range(0, acc_max));
        if (glitch_en && $urandom_range(0, 149) == 0) bus.ready = 1'b0;
      end
    end
  endtask

  task automatic press(input int hold, input int gap);
    btn_raw = 1'b1; cyc(hold);
    btn_raw = 1'b0; cyc(gap);
  endtask

  task automatic stimulus();
    int n, w, n_hi, r0, e0;
    bus.gameover = 1'b0;
    cyc(4);
    chk("rst_enter", int'(bus.enter), 0);
    chk("rst_move", int'(bus.move), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_reject", int'(reject), 0);
    chk("rst_moves", int'(moves_made), 0);
    reset_n = 1'b1;

    // accepted move: latency and strobe width
    sw_move_raw = 3'd3; force_ready = 1'b1; cyc(6);
    r0 = rej_seen;
    btn_raw = 1'b1; n = 0;
    while (!bus.enter && n < 100) begin @(negedge clock); n++; end
    chk("enter_latency", n, 19);
    chk("first_move", int'(bus.move), 3);
    force_ready = 1'b0;
    n_hi = 1; w = 0;
    while (bus.enter && w < 20) begin @(negedge clock); w++; if (bus.enter) n_hi++; end
    chk("enter_width", n_hi, 4);
    cyc(40 - n - w);
    btn_raw = 1'b0; cyc(30);
    chk("accept_count", int'(moves_made), 1);
    chk("accept_no_reject", rej_seen - r0, 0);
    force_ready = 1'b1; cyc(5);

    // out-of-range moves
    for (int k = 0; k < 2; k++) begin
      sw_move_raw = (k == 0) ? 3'd6 : 3'd0; cyc(4);
      r0 = rej_seen; e0 = enter_rises;
      press(30, 40);
      chk("range_reject", rej_seen - r0, 1);
      chk("range_no_enter", enter_rises - e0, 0);
      chk("range_moves", int'(moves_made), 1);
    end

    // core keeps ready high: move refused
    sw_move_raw = 3'd2; cyc(4);
    r0 = rej_seen; e0 = enter_rises;
    press(30, 40);
    chk("refuse_enter", enter_rises - e0, 1);
    chk("refuse_reject", rej_seen - r0, 1);
    chk("refuse_moves", int'(moves_made), 1);

    // bouncing button then a long hold
    core_mode = 1; acc_max = 2; sw_move_raw = 3'd5; cyc(4);
    e0 = enter_rises;
    for (int k = 0; k < 12; k++) begin btn_raw = ~btn_raw; cyc(5); end
    btn_raw = 1'b1; cyc(500);
    btn_raw = 1'b0; cyc(40);
    chk("bounce_one_enter", enter_rises - e0, 1);

    // gameover clear, then saturation
    bus.gameover = 1'b1; cyc(1);
    chk("gameover_clear", int'(moves_made), 0);
    bus.gameover = 1'b0; cyc(3);
    for (int k = 0; k < 15; k++) begin
      sw_move_raw = 3'(1 + k % 5);
      press(30, 60);
    end
    chk("count_15", int'(moves_made), 15);
    r0 = rej_seen; e0 = enter_rises;
    press(30, 60);
    chk("sat_enter", enter_rises - e0, 1);
    chk("sat_no_reject", rej_seen - r0, 0);
    chk("sat_hold", int'(moves_made), 15);
    bus.gameover = 1'b1; cyc(1);
    chk("gameover_clear_sat", int'(moves_made), 0);
    bus.gameover = 1'b0; cyc(3);

    // asynchronous reset while enter is high
    core_mode = 0; force_ready = 1'b1; sw_move_raw = 3'd4; cyc(30);
    btn_raw = 1'b1; n = 0;
    while (!bus.enter && n < 100) begin @(negedge clock); n++; end
    chk("pre_rst_enter", int'(bus.enter), 1);
    #2; reset_n = 1'b0; #1;
    chk("async_rst_enter", int'(bus.enter), 0);
    chk("async_rst_busy", int'(busy), 1);
    @(negedge clock); btn_raw = 1'b0; cyc(2);
    reset_n = 1'b1; #1;
    chk("post_rst_busy", int'(busy), 1);
    chk("post_rst_enter", int'(bus.enter), 0);
    cyc(5);

    // randomized traffic
    core_mode = 1; glitch_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int hold;
      sw_move_raw = 3'($urandom_range(0, 7));
      acc_max = int'($urandom_range(0, 5));
      cyc(int'($urandom_range(2, 10)));
      hold = int'($urandom_range(1, 60));
      btn_raw = 1'b1;
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 15) == 0) btn_raw = ~btn_raw;
        if ($urandom_range(0, 40) == 0) sw_move_raw = 3'($urandom_range(0, 7));
        cyc(1);
      end
      btn_raw = 1'b0;
      cyc(int'($urandom_range(20, 80)));
      if ($urandom_range(0, 4) == 0) begin
        bus.gameover = 1'b1; cyc(int'($urandom_range(1, 3)));
        bus.gameover = 1'b0;
      end
    end
    glitch_en = 1'b0;
    cyc(50);
  endtask

  initial begin
    fork
      check_loop();
      core_loop();
    join_none
    stimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
